// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access and owns the LL/SC link.
// Grants take one cycle after the IDLE request cycle; completion waits on ram_ready, and a failing SC completes without touching RAM.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        datomic,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          link_valid_q, link_valid_d;
  logic [31:0]   link_addr_q, link_addr_d;

  logic dreq, is_sc, sc_fail, idone, ddone;

  assign dreq    = dREN | dWEN;
  assign is_sc   = dWEN & datomic;
  assign sc_fail = is_sc & ~(link_valid_q & (link_addr_q == daddr));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      link_valid_q <= 1'b0;
      link_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      link_valid_q <= link_valid_d;
      link_addr_q  <= link_addr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    link_valid_d = link_valid_q;
    link_addr_d  = link_addr_q;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iload        = '0;
    dload        = '0;
    idone        = 1'b0;
    ddone        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
        if (dreq && (!iREN || streak_q < LIMIT)) begin
          state_d = DGRANT;
          if (iREN) begin
            if (streak_q < LIMIT) streak_d = streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (iREN) begin
          state_d  = IGRANT;
          streak_d = '0;
        end else begin
          streak_d = '0;
        end
      end

      IGRANT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_ready) begin
            idone   = 1'b1;
            iload   = ramload;
            state_d = IDLE;
          end
        end
      end

      DGRANT: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          if (sc_fail) begin
            // Lost link: answer 0 immediately, RAM untouched.
            ddone   = 1'b1;
            state_d = IDLE;
          end else begin
            ramREN = dREN;
            ramWEN = dWEN;
            if (ram_ready) begin
              ddone   = 1'b1;
              state_d = IDLE;
              if (dREN) dload = ramload;
              if (is_sc) begin
                dload        = 32'd1;
                link_valid_d = 1'b0;
              end
              if (dREN && datomic) begin
                link_valid_d = 1'b1;
                link_addr_d  = daddr;
              end
              if (dWEN && !datomic && daddr == link_addr_q) link_valid_d = 1'b0;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase

    iwait = iREN & ~idone;
    dwait = dreq & ~ddone;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed per-cycle vectors for mem_arbiter plus a grant-order sequence under continuous contention.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic        datomic = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = '0;
  logic        ram_ready = 1'b0;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        iren;
    logic [31:0] ia;
    logic        dren;
    logic        dwen;
    logic        dat;
    logic [31:0] da;
    logic [31:0] ds;
    logic [31:0] rl;
    logic        rdy;
    logic        e_iwait;
    logic [31:0] e_iload;
    logic        e_dwait;
    logic [31:0] e_dload;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_raddr;
    logic [31:0] e_rstore;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
      input logic rst, input logic iren, input logic [31:0] ia,
      input logic dren, input logic dwen, input logic dat,
      input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl, input logic rdy,
      input logic e_iwait, input logic [31:0] e_iload, input logic e_dwait, input logic [31:0] e_dload,
      input logic e_ren, input logic e_wen, input logic [31:0] e_raddr, input logic [31:0] e_rstore);
    vec_t v;
    v.rst = rst; v.iren = iren; v.ia = ia; v.dren = dren; v.dwen = dwen; v.dat = dat;
    v.da = da; v.ds = ds; v.rl = rl; v.rdy = rdy;
    v.e_iwait = e_iwait; v.e_iload = e_iload; v.e_dwait = e_dwait; v.e_dload = e_dload;
    v.e_ren = e_ren; v.e_wen = e_wen; v.e_raddr = e_raddr; v.e_rstore = e_rstore;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  initial begin
    string order;
    int    g;
    byte   gch;

    //            rst iR iaddr     dR dW at daddr     dstore    ramload       rdy  iw iload         dw dload         rR rW raddr     rstore
    vq.push_back(mk(0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,    32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 0 reset
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,    32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 1 idle
    vq.push_back(mk(1, 1, 32'h40,  0, 0, 0, 32'h0,   32'h0,    32'h0,        0,   1, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 2 fetch seen
    vq.push_back(mk(1, 1, 32'h40,  0, 0, 0, 32'h0,   32'h0,    32'h2402000A, 1,   0, 32'h2402000A, 0, 32'h0,        1, 0, 32'h40,  32'h0));   // 3 fetch done
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,    32'h2402000A, 1,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 4 idle
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 1, 32'h100, 32'h0,    32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 5 LL seen
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 1, 32'h100, 32'h0,    32'h12345678, 1,   0, 32'h0,        0, 32'h12345678, 1, 0, 32'h100, 32'h0));   // 6 LL done
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h100, 32'hBEEF, 32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 7 SC seen
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h100, 32'hBEEF, 32'h0,        1,   0, 32'h0,        0, 32'h1,        0, 1, 32'h100, 32'hBEEF)); // 8 SC ok
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h100, 32'hBEEF, 32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 9 SC2 seen
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h100, 32'hBEEF, 32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0, 32'h100, 32'hBEEF)); // 10 SC2 fail
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,    32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 11 idle
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h300, 32'h0,    32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 12 LW seen
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h300, 32'h0,    32'h0,        0,   0, 32'h0,        1, 32'h0,        1, 0, 32'h300, 32'h0));   // 13 stall
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h300, 32'h0,    32'h0,        0,   0, 32'h0,        1, 32'h0,        1, 0, 32'h300, 32'h0));   // 14 stall
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h300, 32'h0,    32'h0,        0,   0, 32'h0,        1, 32'h0,        1, 0, 32'h300, 32'h0));   // 15 stall
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 0, 32'h300, 32'h0,    32'hCAFEF00D, 1,   0, 32'h0,        0, 32'hCAFEF00D, 1, 0, 32'h300, 32'h0));   // 16 LW done
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 1, 32'h200, 32'h0,    32'h55,       1,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 17 LL seen
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 1, 32'h200, 32'h0,    32'h55,       1,   0, 32'h0,        0, 32'h55,       1, 0, 32'h200, 32'h0));   // 18 LL done
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 0, 32'h200, 32'h77,   32'h0,        1,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 19 SW seen
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 0, 32'h200, 32'h77,   32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 1, 32'h200, 32'h77));  // 20 SW done
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h200, 32'h99,   32'h0,        1,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 21 SC seen
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h200, 32'h99,   32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 0, 32'h200, 32'h99));  // 22 SC fail
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 1, 32'h400, 32'h0,    32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 23 LL seen
    vq.push_back(mk(1, 0, 32'h0,   1, 0, 1, 32'h400, 32'h0,    32'h1,        1,   0, 32'h0,        0, 32'h1,        1, 0, 32'h400, 32'h0));   // 24 LL done
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h400, 32'hAA,   32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 25 SC seen
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h400, 32'hAA,   32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 1, 32'h400, 32'hAA));  // 26 SC granted
    vq.push_back(mk(0, 0, 32'h0,   0, 1, 1, 32'h400, 32'hAA,   32'h0,        0,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 27 reset mid-grant
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h400, 32'hAA,   32'h0,        1,   0, 32'h0,        1, 32'h0,        0, 0, 32'h0,   32'h0));   // 28 SC seen
    vq.push_back(mk(1, 0, 32'h0,   0, 1, 1, 32'h400, 32'hAA,   32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 0, 32'h400, 32'hAA));  // 29 SC fail, link lost
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,    32'h0,        0,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 30 idle
    vq.push_back(mk(1, 1, 32'h80,  0, 0, 0, 32'h0,   32'h0,    32'h0,        0,   1, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 31 fetch seen
    vq.push_back(mk(1, 0, 32'h80,  0, 0, 0, 32'h0,   32'h0,    32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 32 withdrawn
    vq.push_back(mk(1, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,    32'h0,        1,   0, 32'h0,        0, 32'h0,        0, 0, 32'h0,   32'h0));   // 33 idle

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge CLK);
      nRST = vq[i].rst; iREN = vq[i].iren; iaddr = vq[i].ia;
      dREN = vq[i].dren; dWEN = vq[i].dwen; datomic = vq[i].dat;
      daddr = vq[i].da; dstore = vq[i].ds; ramload = vq[i].rl; ram_ready = vq[i].rdy;
      #1;
      chk("iwait",    i, {31'b0, iwait},  {31'b0, vq[i].e_iwait});
      chk("iload",    i, iload,           vq[i].e_iload);
      chk("dwait",    i, {31'b0, dwait},  {31'b0, vq[i].e_dwait});
      chk("dload",    i, dload,           vq[i].e_dload);
      chk("ramREN",   i, {31'b0, ramREN}, {31'b0, vq[i].e_ren});
      chk("ramWEN",   i, {31'b0, ramWEN}, {31'b0, vq[i].e_wen});
      chk("ramaddr",  i, ramaddr,         vq[i].e_raddr);
      chk("ramstore", i, ramstore,        vq[i].e_rstore);
    end

    // Contention: both requesters held, RAM always ready.
    order = "DDDDIDDDDI";
    g = 0;
    @(negedge CLK);
    iREN = 1'b1; iaddr = 32'h40; dREN = 1'b1; dWEN = 1'b0; datomic = 1'b0;
    daddr = 32'h300; ram_ready = 1'b1; ramload = 32'h0;
    for (int cyc = 0; cyc < 200 && g < 10; cyc++) begin
      #1;
      if (ramREN) begin
        gch = (ramaddr == 32'h300) ? "D" : "I";
        total++;
        if (gch != order[g]) begin
          bad++;
          $display("FAIL grant_order idx=%0d got=%s want=%s", g, gch, order[g]);
        end
        g++;
      end
      @(negedge CLK);
    end
    total++;
    if (g < 10) begin
      bad++;
      $display("FAIL grant_count got=%0d want=10", g);
    end
    iREN = 1'b0; dREN = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
